// File: rtl/satd_sequencer.sv
// satd_sequencer: control FSM for a 4x4 SATD datapath.
//   The flow is IDLE -> CLEAR -> LOAD (4 row beats) -> COLT (4 column passes)
//   -> DONE, which waits for the result handshake.
// Ports:
//   clk, rst (async active-low), start        - control inputs
//   in_valid / in_ready                        - row-beat handshake
//   ENABLE_DIFF, RESET_DIFF                    - difference stage enable/clear
//   HAD_ROW_EN, ROW_IDX                        - horizontal transform, row index
//   HAD_COL_EN, COL_IDX                        - vertical transform, column index
//   ACC_CLR, ACC_EN                            - absolute-sum accumulator
//   out_valid / out_ready                      - result handshake
//   busy                                       - high whenever not IDLE
//   COUNTER                                    - completed blocks, wraps at 16
// Config macro: SATD_BLOCK_CNT_EN builds the completed-block counter;
//   without it COUNTER is tied to 0 and no counter flops exist.
module satd_sequencer #(
  parameter int ROWS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ENABLE_DIFF,
  output logic       RESET_DIFF,
  output logic       HAD_ROW_EN,
  output logic [1:0] ROW_IDX,
  output logic       HAD_COL_EN,
  output logic [1:0] COL_IDX,
  output logic       ACC_CLR,
  output logic       ACC_EN,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [3:0] COUNTER
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COLT, DONE} state_e;

  localparam logic [1:0] LAST = 2'(ROWS - 1);

  state_e     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic       in_ready_q, in_ready_d;
  logic       reset_diff_q, reset_diff_d;
  logic       col_en_q, col_en_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       done_hs;

  // in_ready is a flop, so accept is a flop ANDed with the input handshake.
  assign accept  = in_ready_q & in_valid;
  assign done_hs = (state_q == DONE) & out_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        state_d = LOAD;
        row_d   = '0;
      end
      LOAD: if (accept) begin
        row_d = row_q + 2'd1;             // wraps to 0 after the last row
        if (row_q == LAST) begin
          state_d = COLT;
          col_d   = '0;
        end
      end
      COLT: begin
        col_d = col_q + 2'd1;
        if (col_q == LAST) state_d = DONE;
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with it.
    in_ready_d   = (state_d == LOAD);
    reset_diff_d = (state_d == CLEAR);
    col_en_d     = (state_d == COLT);
    out_valid_d  = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      in_ready_q   <= 1'b0;
      reset_diff_q <= 1'b0;
      col_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      in_ready_q   <= in_ready_d;
      reset_diff_q <= reset_diff_d;
      col_en_q     <= col_en_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  // Row strobes fire in the accept cycle itself so the datapath writes the
  // row being presented; ROW_IDX already holds that row's index.
  assign ENABLE_DIFF = accept;
  assign HAD_ROW_EN  = accept;
  assign ROW_IDX     = row_q;
  assign RESET_DIFF  = reset_diff_q;
  assign ACC_CLR     = reset_diff_q;
  assign HAD_COL_EN  = col_en_q;
  assign ACC_EN      = col_en_q;
  assign COL_IDX     = col_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;

`ifdef SATD_BLOCK_CNT_EN
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (done_hs) cnt_d = cnt_q + 4'd1;    // natural wrap 15 -> 0
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign COUNTER = cnt_q;
`else
  logic unused_done_hs;
  assign unused_done_hs = done_hs;
  assign COUNTER        = '0;
`endif

endmodule

// File: tb/tb_satd_sequencer.sv
// Directed bench for satd_sequencer: reset, nominal block, input gaps,
// result stall, mid-block reset, back-to-back blocks with counter wrap.
module tb_satd_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic       in_ready, ENABLE_DIFF, RESET_DIFF, HAD_ROW_EN, HAD_COL_EN;
  logic       ACC_CLR, ACC_EN, out_valid, busy;
  logic [1:0] ROW_IDX, COL_IDX;
  logic [3:0] COUNTER;
  logic [16:0] outs;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  satd_sequencer #(.ROWS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .ENABLE_DIFF(ENABLE_DIFF), .RESET_DIFF(RESET_DIFF),
    .HAD_ROW_EN(HAD_ROW_EN), .ROW_IDX(ROW_IDX), .HAD_COL_EN(HAD_COL_EN),
    .COL_IDX(COL_IDX), .ACC_CLR(ACC_CLR), .ACC_EN(ACC_EN),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .COUNTER(COUNTER)
  );

  always #5 clk = ~clk;

  assign outs = {in_ready, ENABLE_DIFF, RESET_DIFF, HAD_ROW_EN, HAD_COL_EN,
                 ACC_CLR, ACC_EN, out_valid, busy, ROW_IDX, COL_IDX, COUNTER};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bump_cnt();
`ifdef SATD_BLOCK_CNT_EN
    exp_cnt = (exp_cnt + 1) % 16;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_chk++; if (outs !== 17'h0) begin n_fail++; $display("FAIL reset_async: outs=%h want 0", outs); end
    step(); step();
    n_chk++; if (outs !== 17'h0) begin n_fail++; $display("FAIL reset_held: outs=%h want 0", outs); end
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  // Starts right after reset release: the first edge must capture start.
  task automatic test_basic();
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step(); start = 1'b0;
    n_chk++; if ({RESET_DIFF, ACC_CLR, busy, in_ready, ENABLE_DIFF} !== 5'b11100) begin
      n_fail++; $display("FAIL basic_clear: rd,ac,busy,rdy,en=%b want 11100",
                         {RESET_DIFF, ACC_CLR, busy, in_ready, ENABLE_DIFF}); end
    for (int r = 0; r < 4; r++) begin
      step();
      n_chk++; if ({in_ready, ENABLE_DIFF, HAD_ROW_EN, RESET_DIFF, ROW_IDX} !== {3'b111, 1'b0, 2'(r)}) begin
        n_fail++; $display("FAIL basic_load%0d: rdy,en,row_en,rd,row=%b want %b", r,
                           {in_ready, ENABLE_DIFF, HAD_ROW_EN, RESET_DIFF, ROW_IDX}, {3'b111, 1'b0, 2'(r)}); end
    end
    for (int c = 0; c < 4; c++) begin
      step();
      n_chk++; if ({HAD_COL_EN, ACC_EN, ENABLE_DIFF, in_ready, out_valid, COL_IDX} !== {5'b11000, 2'(c)}) begin
        n_fail++; $display("FAIL basic_colt%0d: col_en,acc_en,en,rdy,ov,col=%b want %b", c,
                           {HAD_COL_EN, ACC_EN, ENABLE_DIFF, in_ready, out_valid, COL_IDX}, {5'b11000, 2'(c)}); end
    end
    step();  // tenth edge since start
    n_chk++; if ({out_valid, busy, HAD_COL_EN} !== 3'b110) begin
      n_fail++; $display("FAIL basic_done: ov,busy,col_en=%b want 110", {out_valid, busy, HAD_COL_EN}); end
    step(); bump_cnt();
    n_chk++; if ({out_valid, busy} !== 2'b00 || COUNTER !== 4'(exp_cnt)) begin
      n_fail++; $display("FAIL basic_exit: ov,busy=%b cnt=%0d want 00 cnt=%0d", {out_valid, busy}, COUNTER, exp_cnt); end
  endtask

  task automatic test_gaps_and_stall();
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int acc = 0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); start = 1'b0;
    step();
    start = 1'b1;  // ignored in LOAD, COLT and DONE
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i][0];
      #1;
      n_chk++; if ({ENABLE_DIFF, HAD_COL_EN, ROW_IDX} !== {pat[i][0], 1'b0, 2'(acc)}) begin
        n_fail++; $display("FAIL gap%0d: en,col_en,row=%b want %b", i,
                           {ENABLE_DIFF, HAD_COL_EN, ROW_IDX}, {pat[i][0], 1'b0, 2'(acc)}); end
      @(posedge clk); #1;
      acc += pat[i];
    end
    in_valid = 1'b0;
    n_chk++; if ({HAD_COL_EN, in_ready, COL_IDX, ROW_IDX} !== 6'b100000) begin
      n_fail++; $display("FAIL gap_colt: col_en,rdy,col,row=%b want 100000",
                         {HAD_COL_EN, in_ready, COL_IDX, ROW_IDX}); end
    repeat (4) step();
    for (int k = 0; k < 6; k++) begin
      n_chk++; if ({out_valid, busy} !== 2'b11 || COUNTER !== 4'(exp_cnt)) begin
        n_fail++; $display("FAIL stall%0d: ov,busy=%b cnt=%0d want 11 cnt=%0d", k, {out_valid, busy}, COUNTER, exp_cnt); end
      if (k < 5) step();
    end
    out_ready = 1'b1;  // start still high in the exit cycle
    step(); bump_cnt();
    start = 1'b0; out_ready = 1'b0;
    n_chk++; if ({out_valid, busy} !== 2'b00 || COUNTER !== 4'(exp_cnt)) begin
      n_fail++; $display("FAIL stall_exit: ov,busy=%b cnt=%0d want 00 cnt=%0d", {out_valid, busy}, COUNTER, exp_cnt); end
    step(); step();
    n_chk++; if ({busy, RESET_DIFF} !== 2'b00) begin
      n_fail++; $display("FAIL no_capture: busy,rd=%b want 00", {busy, RESET_DIFF}); end
    start = 1'b1;
    step(); start = 1'b0;
    n_chk++; if ({busy, RESET_DIFF} !== 2'b11) begin
      n_fail++; $display("FAIL restart: busy,rd=%b want 11", {busy, RESET_DIFF}); end
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 30 && busy === 1'b1; k++) step();
    bump_cnt();
    n_chk++; if (busy !== 1'b0 || COUNTER !== 4'(exp_cnt)) begin
      n_fail++; $display("FAIL drain: busy=%b cnt=%0d want 0 cnt=%0d", busy, COUNTER, exp_cnt); end
  endtask

  task automatic run_block(input int idx);
    int lat = 0;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    do begin step(); lat++; start = 1'b0; end while (out_valid !== 1'b1 && lat < 40);
    n_chk++; if (lat != 10) begin
      n_fail++; $display("FAIL latency_blk%0d: got %0d cycles want 10", idx, lat); end
    step(); bump_cnt();
    n_chk++; if (busy !== 1'b0 || COUNTER !== 4'(exp_cnt)) begin
      n_fail++; $display("FAIL count_blk%0d: busy=%b cnt=%0d want 0 cnt=%0d", idx, busy, COUNTER, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step(); start = 1'b0;
    repeat (7) step();
    n_chk++; if ({HAD_COL_EN, COL_IDX} !== 3'b110) begin
      n_fail++; $display("FAIL mid_colt: col_en,col=%b want 110", {HAD_COL_EN, COL_IDX}); end
    #2 rst = 1'b0;
    #1;
    exp_cnt = 0;
    n_chk++; if (outs !== 17'h0) begin n_fail++; $display("FAIL mid_reset: outs=%h want 0", outs); end
    #1 rst = 1'b1;
    step();
    run_block(0);
  endtask

  task automatic test_back_to_back();
    rst = 1'b0; #2 rst = 1'b1;
    exp_cnt = 0;
    step();
    for (int b = 1; b <= 17; b++) run_block(b);
`ifdef SATD_BLOCK_CNT_EN
    n_chk++; if (COUNTER !== 4'd1) begin n_fail++; $display("FAIL wrap: cnt=%0d want 1", COUNTER); end
`else
    n_chk++; if (COUNTER !== 4'd0) begin n_fail++; $display("FAIL wrap: cnt=%0d want 0", COUNTER); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps_and_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
